// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the timing generator and pixel renderers.
package vga_timing_pkg;

  localparam int unsigned CntW = 10;
  typedef logic [CntW-1:0] cnt_t;

  localparam int unsigned VgaClkDiv    = 4;
  localparam int unsigned VgaHTotal    = 800;
  localparam int unsigned VgaHSync     = 96;
  localparam int unsigned VgaHActStart = 144;
  localparam int unsigned VgaHActEnd   = 784;
  localparam int unsigned VgaVTotal    = 525;
  localparam int unsigned VgaVSync     = 2;
  localparam int unsigned VgaVActStart = 35;
  localparam int unsigned VgaVActEnd   = 515;

  localparam int unsigned VgaHActive = VgaHActEnd - VgaHActStart;
  localparam int unsigned VgaVActive = VgaVActEnd - VgaVActStart;

  // Half-open window test [lo, hi).
  function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the VGA timing generator to its consumers.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic pix_en;
  logic frame_start;
  cnt_t hCount;
  cnt_t vCount;
  logic hSync;
  logic vSync;
  logic bright;

  modport master (
    output pix_en, frame_start, hCount, vCount, hSync, vSync, bright
  );

  modport slave (
    input pix_en, frame_start, hCount, vCount, hSync, vSync, bright
  );

endinterface

// File: rtl/pix_en_gen.sv
// Pixel-enable divider: one-clock strobe every CLK_DIV system clocks.
module pix_en_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q;
  logic [DivW-1:0] div_d;
  logic            div_last;

  assign div_last = (div_q == DivLast);

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_last) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Gated by reset so a pending strobe never escapes a reset cycle (matters for CLK_DIV=1).
  assign pix_en = div_last & ~reset;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered syncs and visible-window flag.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = VgaClkDiv,
  parameter int unsigned H_TOTAL     = VgaHTotal,
  parameter int unsigned H_SYNC      = VgaHSync,
  parameter int unsigned H_ACT_START = VgaHActStart,
  parameter int unsigned H_ACT_END   = VgaHActEnd,
  parameter int unsigned V_TOTAL     = VgaVTotal,
  parameter int unsigned V_SYNC      = VgaVSync,
  parameter int unsigned V_ACT_START = VgaVActStart,
  parameter int unsigned V_ACT_END   = VgaVActEnd
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  logic pix_en;
  logic h_wrap;
  logic v_wrap;
  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic hsync_q, vsync_q, bright_q;

  pix_en_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_en_gen (
    .clk   (clk),
    .reset (reset),
    .pix_en(pix_en)
  );

  assign h_wrap = (h_q == cnt_t'(H_TOTAL - 1));
  assign v_wrap = (v_q == cnt_t'(V_TOTAL - 1));

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Syncs and bright are derived from next-state counts so they line up with the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= (h_d >= cnt_t'(H_SYNC));
      vsync_q  <= (v_d >= cnt_t'(V_SYNC));
      bright_q <= in_window(h_d, cnt_t'(H_ACT_START), cnt_t'(H_ACT_END)) &&
                  in_window(v_d, cnt_t'(V_ACT_START), cnt_t'(V_ACT_END));
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.frame_start = pix_en & h_wrap & v_wrap;
  assign vga.hCount      = h_q;
  assign vga.vCount      = v_q;
  assign vga.hSync       = hsync_q;
  assign vga.vSync       = vsync_q;
  assign vga.bright      = bright_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, reduced-raster and CLK_DIV=1 builds against a raster model.
module tb_vga_timing_gen;

  localparam int BD = 2, BH = 20, BHS = 3, BHA0 = 5, BHA1 = 17;
  localparam int BV = 10, BVS = 2, BVA0 = 3, BVA1 = 8;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_a = 0;
  int   n_b = 0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen dut_a (
    .clk  (clk),
    .reset(rst_a),
    .vga  (if_a)
  );

  vga_timing_gen #(
    .CLK_DIV(BD), .H_TOTAL(BH), .H_SYNC(BHS), .H_ACT_START(BHA0), .H_ACT_END(BHA1),
    .V_TOTAL(BV), .V_SYNC(BVS), .V_ACT_START(BVA0), .V_ACT_END(BVA1)
  ) dut_b (
    .clk  (clk),
    .reset(rst_b),
    .vga  (if_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1)
  ) dut_c (
    .clk  (clk),
    .reset(rst_a),
    .vga  (if_c)
  );

  // Clocks elapsed since the last clock edge that saw reset high.
  always @(posedge clk) begin
    n_a <= rst_a ? 0 : n_a + 1;
    n_b <= rst_b ? 0 : n_b + 1;
  end

  // Raster model: pixel index = clocks / div, laid out row-major over the frame.
  function automatic int m_h(int n, int d, int ht);
    return (n / d) % ht;
  endfunction

  function automatic int m_v(int n, int d, int ht, int vt);
    return (n / d / ht) % vt;
  endfunction

  function automatic bit m_pe(int n, int d);
    return ((n + 1) % d) == 0;
  endfunction

  function automatic bit m_in(int x, int lo, int hi);
    return (x >= lo) && (x < hi);
  endfunction

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if ({if_a.pix_en, if_a.frame_start, if_a.hSync, if_a.vSync, if_a.bright, if_a.hCount,
         if_a.vCount} !== 25'd0) begin
      err_cnt++;
      $display("FAIL reset_a: outputs %h want 0", {if_a.pix_en, if_a.frame_start, if_a.hSync,
               if_a.vSync, if_a.bright, if_a.hCount, if_a.vCount});
    end
    cmp_cnt++;
    if ({if_b.pix_en, if_b.frame_start, if_b.hSync, if_b.vSync, if_b.bright, if_b.hCount,
         if_b.vCount} !== 25'd0) begin
      err_cnt++;
      $display("FAIL reset_b: outputs %h want 0", {if_b.pix_en, if_b.frame_start, if_b.hSync,
               if_b.vSync, if_b.bright, if_b.hCount, if_b.vCount});
    end
    cmp_cnt++;
    if ({if_c.pix_en, if_c.frame_start, if_c.hSync, if_c.vSync, if_c.bright, if_c.hCount,
         if_c.vCount} !== 25'd0) begin
      err_cnt++;
      $display("FAIL reset_c: outputs %h want 0", {if_c.pix_en, if_c.frame_start, if_c.hSync,
               if_c.vSync, if_c.bright, if_c.hCount, if_c.vCount});
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  task automatic test_pix_en();
    int pulses = 0;
    int last = -1;
    for (int i = 0; i < 4; i++) begin
      if (if_a.pix_en === 1'b1) pulses++;
      @(negedge clk);
    end
    cmp_cnt++;
    if (pulses != 1) begin
      err_cnt++;
      $display("FAIL first_pix_en: %0d pulses in 4 clks, want 1", pulses);
    end
    cmp_cnt++;
    if (if_a.hCount !== 10'd1) begin
      err_cnt++;
      $display("FAIL first_advance: hCount %0d want 1", if_a.hCount);
    end
    for (int i = 0; i < 64; i++) begin
      cmp_cnt++;
      if (if_a.pix_en !== m_pe(n_a, 4)) begin
        err_cnt++;
        $display("FAIL pix_en_a: n=%0d got %b want %b", n_a, if_a.pix_en, m_pe(n_a, 4));
      end
      cmp_cnt++;
      if (if_a.hCount !== 10'(m_h(n_a, 4, 800))) begin
        err_cnt++;
        $display("FAIL hcount_a: n=%0d got %0d want %0d", n_a, if_a.hCount, m_h(n_a, 4, 800));
      end
      if (if_a.pix_en === 1'b1) begin
        if (last >= 0) begin
          cmp_cnt++;
          if (n_a - last != 4) begin
            err_cnt++;
            $display("FAIL pix_en_period: got %0d want 4", n_a - last);
          end
        end
        last = n_a;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_line();
    int low = 0, high = 0, eh, ev;
    while (n_a < 2 * 4 * 800 + 4) begin
      eh = m_h(n_a, 4, 800);
      ev = m_v(n_a, 4, 800, 525);
      cmp_cnt++;
      if ({if_a.hCount, if_a.vCount} !== {10'(eh), 10'(ev)}) begin
        err_cnt++;
        $display("FAIL count_a: got (%0d,%0d) want (%0d,%0d)", if_a.hCount, if_a.vCount, eh, ev);
      end
      cmp_cnt++;
      if ({if_a.hSync, if_a.vSync, if_a.bright} !==
          {eh >= 96, ev >= 2, m_in(eh, 144, 784) && m_in(ev, 35, 515)}) begin
        err_cnt++;
        $display("FAIL sync_a: (%0d,%0d) hs/vs/br got %b%b%b", eh, ev, if_a.hSync, if_a.vSync,
                 if_a.bright);
      end
      if (ev == 1 && m_pe(n_a, 4)) begin
        if (if_a.hSync === 1'b0) begin
          if (eh < 96) low++;
        end else begin
          high++;
        end
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (low != 96 || high != 704) begin
      err_cnt++;
      $display("FAIL hsync_width: low %0d high %0d want 96 704", low, high);
    end
    cmp_cnt++;
    if (if_a.vCount !== 10'd2) begin
      err_cnt++;
      $display("FAIL line_wrap: vCount %0d want 2", if_a.vCount);
    end
  endtask

  task automatic test_frame();
    int fs = 0, br = 0, eh, ev;
    int stop = n_b + BD * BH * BV;
    bit epe;
    while (n_b < stop) begin
      eh  = m_h(n_b, BD, BH);
      ev  = m_v(n_b, BD, BH, BV);
      epe = m_pe(n_b, BD);
      cmp_cnt++;
      if ({if_b.pix_en, if_b.frame_start} !== {epe, epe && eh == BH - 1 && ev == BV - 1}) begin
        err_cnt++;
        $display("FAIL strobes_b: (%0d,%0d) pe/fs got %b%b", eh, ev, if_b.pix_en,
                 if_b.frame_start);
      end
      cmp_cnt++;
      if ({if_b.hCount, if_b.vCount} !== {10'(eh), 10'(ev)}) begin
        err_cnt++;
        $display("FAIL count_b: got (%0d,%0d) want (%0d,%0d)", if_b.hCount, if_b.vCount, eh, ev);
      end
      cmp_cnt++;
      if ({if_b.hSync, if_b.vSync, if_b.bright} !==
          {eh >= BHS, ev >= BVS, m_in(eh, BHA0, BHA1) && m_in(ev, BVA0, BVA1)}) begin
        err_cnt++;
        $display("FAIL sync_b: (%0d,%0d) hs/vs/br got %b%b%b", eh, ev, if_b.hSync, if_b.vSync,
                 if_b.bright);
      end
      if (if_b.frame_start === 1'b1) fs++;
      if (if_b.pix_en === 1'b1 && if_b.bright === 1'b1) br++;
      @(negedge clk);
    end
    cmp_cnt++;
    if (fs != 1) begin
      err_cnt++;
      $display("FAIL frame_start_count: got %0d want 1", fs);
    end
    cmp_cnt++;
    if (br != (BHA1 - BHA0) * (BVA1 - BVA0)) begin
      err_cnt++;
      $display("FAIL bright_count: got %0d want %0d", br, (BHA1 - BHA0) * (BVA1 - BVA0));
    end
  endtask

  task automatic test_bright_points();
    int ph[6], pv[6], eh, ev;
    bit pb[6], seen[6];
    ph = '{BHA0 - 1, BHA1, BHA0, BHA0, BHA0, BHA1 - 1};
    pv = '{BVA0, BVA0, BVA0 - 1, BVA1, BVA0, BVA1 - 1};
    pb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    seen = '{default: 1'b0};
    for (int i = 0; i < BD * BH * BV + BD; i++) begin
      eh = m_h(n_b, BD, BH);
      ev = m_v(n_b, BD, BH, BV);
      for (int k = 0; k < 6; k++) begin
        if (m_pe(n_b, BD) && eh == ph[k] && ev == pv[k] && !seen[k]) begin
          seen[k] = 1'b1;
          cmp_cnt++;
          if (if_b.bright !== pb[k]) begin
            err_cnt++;
            $display("FAIL bright_point: (%0d,%0d) got %b want %b", eh, ev, if_b.bright, pb[k]);
          end
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 6; k++) begin
      cmp_cnt++;
      if (!seen[k]) begin
        err_cnt++;
        $display("FAIL point_reach: (%0d,%0d) not reached, want reached", ph[k], pv[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int th, tv, eh, ev;
    bit found;
    for (int it = 0; it < 3; it++) begin
      th = (it == 0) ? 10 : (it == 1) ? int'($urandom_range(BH - 1, 1)) : BH - 1;
      tv = (it == 0) ? 5 : (it == 1) ? int'($urandom_range(BV - 2, 1)) : BV - 1;
      found = 1'b0;
      for (int i = 0; i < 2 * BD * BH * BV && !found; i++) begin
        if (m_h(n_b, BD, BH) == th && m_v(n_b, BD, BH, BV) == tv &&
            (it != 2 || m_pe(n_b, BD))) found = 1'b1;
        else @(negedge clk);
      end
      cmp_cnt++;
      if (!found) begin
        err_cnt++;
        $display("FAIL reset_target: (%0d,%0d) not reached, want reached", th, tv);
      end
      rst_b = 1'b1;
      #1;
      cmp_cnt++;
      if ({if_b.pix_en, if_b.frame_start} !== 2'b00) begin
        err_cnt++;
        $display("FAIL reset_override: pe/fs got %b%b want 00", if_b.pix_en, if_b.frame_start);
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        cmp_cnt++;
        if ({if_b.pix_en, if_b.frame_start, if_b.hSync, if_b.vSync, if_b.bright, if_b.hCount,
             if_b.vCount} !== 25'd0) begin
          err_cnt++;
          $display("FAIL mid_reset: clk %0d outputs %h want 0", i, {if_b.pix_en,
                   if_b.frame_start, if_b.hSync, if_b.vSync, if_b.bright, if_b.hCount,
                   if_b.vCount});
        end
      end
      rst_b = 1'b0;
      for (int i = 0; i < 3 * BD * BH; i++) begin
        eh = m_h(n_b, BD, BH);
        ev = m_v(n_b, BD, BH, BV);
        cmp_cnt++;
        if ({if_b.hCount, if_b.vCount, if_b.frame_start} !== {10'(eh), 10'(ev), 1'b0}) begin
          err_cnt++;
          $display("FAIL resume: got (%0d,%0d,fs=%b) want (%0d,%0d,fs=0)", if_b.hCount,
                   if_b.vCount, if_b.frame_start, eh, ev);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_clkdiv1();
    int eh, ev, last_start = -1, lines = 0;
    while (n_a < 36 * 800 + 50) begin
      eh = n_a % 800;
      ev = (n_a / 800) % 525;
      cmp_cnt++;
      if (if_c.pix_en !== 1'b1) begin
        err_cnt++;
        $display("FAIL pix_en_c: n=%0d got %b want 1", n_a, if_c.pix_en);
      end
      cmp_cnt++;
      if ({if_c.hCount, if_c.vCount} !== {10'(eh), 10'(ev)}) begin
        err_cnt++;
        $display("FAIL count_c: got (%0d,%0d) want (%0d,%0d)", if_c.hCount, if_c.vCount, eh, ev);
      end
      cmp_cnt++;
      if ({if_c.hSync, if_c.vSync, if_c.bright} !==
          {eh >= 96, ev >= 2, m_in(eh, 144, 784) && m_in(ev, 35, 515)}) begin
        err_cnt++;
        $display("FAIL sync_c: (%0d,%0d) hs/vs/br got %b%b%b", eh, ev, if_c.hSync, if_c.vSync,
                 if_c.bright);
      end
      if (if_c.hCount === 10'd0) begin
        if (last_start >= 0) begin
          cmp_cnt++;
          if (n_a - last_start != 800) begin
            err_cnt++;
            $display("FAIL line_period_c: got %0d want 800", n_a - last_start);
          end
        end
        last_start = n_a;
        lines++;
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (lines < 20) begin
      err_cnt++;
      $display("FAIL line_starts_c: got %0d want >= 20", lines);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pix_en();
    test_line();
    test_frame();
    test_bright_points();
    test_mid_reset();
    test_clkdiv1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
